// File: rtl/cim_array_scheduler.sv
// rtl/cim_array_scheduler.sv - refresh/DAC-read/MAV-write sequencer and arbiter for the CIM input DRAM array
// Optional watchdog on the WAIT states: define SCHED_TIMEOUT_EN.
module cim_array_scheduler #(
  parameter int ADDR_W         = 6,
  parameter int ROWS           = 64,
  parameter int REFRESH_PERIOD = 1024,
  parameter int WR_CYCLES      = 2,
  parameter int TIMEOUT        = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_dac,
  input  logic [ADDR_W-1:0] req_dac_addr,
  input  logic              req_mav,
  input  logic [ADDR_W-1:0] req_mav_addr,
  input  logic              refresh_finish,
  input  logic              ADC_finish,
  output logic [ADDR_W-1:0] ADDR,
  output logic              WE,
  output logic              DRAM_EN,
  output logic              DEC_EN,
  output logic              start_refresh,
  output logic              start_DAC,
  output logic              gnt_dac,
  output logic              gnt_mav,
  output logic              busy,
  output logic              refresh_overrun,
  output logic              timeout_err
);

  localparam int TW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam int CW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

  typedef enum logic [3:0] {
    IDLE, REF_SETUP, REF_START, REF_WAIT, RD_SETUP, RD_START, RD_WAIT, WR_SETUP, WR_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q;
  logic              wrap, clr;
  logic              pend_q, pend_d, ovr_q, ovr_d;
  logic [ADDR_W-1:0] ref_row_q, ref_row_d, addr_q, addr_d;
  logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
  logic we_q, we_d, dram_q, dram_d, dec_q, dec_d, sref_q, sref_d, sdac_q, sdac_d;
  logic gd_q, gd_d, gm_q, gm_d, busy_q, busy_d;

`ifdef SCHED_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_q, wd_d;
  logic          tmo_hit, tmo_set, tmo_q;
  assign tmo_hit = (wd_q == WW'(TIMEOUT - 1));
`endif

  assign wrap = (timer_q == TW'(REFRESH_PERIOD - 1));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ref_row_d = ref_row_q;
    wr_cnt_d  = wr_cnt_q;
    clr       = 1'b0;
    gd_d      = 1'b0;
    gm_d      = 1'b0;
`ifdef SCHED_TIMEOUT_EN
    tmo_set   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d = REF_SETUP;
          addr_d  = ref_row_q;
        end else if (req_dac) begin
          state_d = RD_SETUP;
          addr_d  = req_dac_addr;
        end else if (req_mav) begin
          state_d = WR_SETUP;
          addr_d  = req_mav_addr;
        end
      end
      REF_SETUP: state_d = REF_START;
      REF_START: state_d = REF_WAIT;
      REF_WAIT: begin
        if (refresh_finish) begin
          state_d   = IDLE;
          addr_d    = '0;
          clr       = 1'b1;
          ref_row_d = (ref_row_q == ADDR_W'(ROWS - 1)) ? '0 : ref_row_q + 1'b1;
`ifdef SCHED_TIMEOUT_EN
        end else if (tmo_hit) begin
          state_d = IDLE;
          addr_d  = '0;
          tmo_set = 1'b1;
`endif
        end
      end
      RD_SETUP: state_d = RD_START;
      RD_START: state_d = RD_WAIT;
      RD_WAIT: begin
        if (ADC_finish) begin
          state_d = IDLE;
          addr_d  = '0;
          gd_d    = 1'b1;
`ifdef SCHED_TIMEOUT_EN
        end else if (tmo_hit) begin
          state_d = IDLE;
          addr_d  = '0;
          tmo_set = 1'b1;
`endif
        end
      end
      WR_SETUP: begin
        state_d  = WR_HOLD;
        wr_cnt_d = '0;
      end
      WR_HOLD: begin
        if (wr_cnt_q == CW'(WR_CYCLES - 1)) begin
          state_d = IDLE;
          addr_d  = '0;
          gm_d    = 1'b1;
        end else begin
          wr_cnt_d = wr_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        addr_d  = '0;
      end
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    busy_d = (state_d != IDLE);
    dec_d  = busy_d;
    we_d   = (state_d == WR_HOLD);
    dram_d = (state_d inside {REF_SETUP, REF_START, REF_WAIT, RD_SETUP, RD_START, RD_WAIT, WR_HOLD});
    sref_d = (state_d == REF_START);
    sdac_d = (state_d == RD_START);

    // A wrap coinciding with the clear keeps the refresh pending and is not an overrun.
    pend_d = wrap ? 1'b1 : (clr ? 1'b0 : pend_q);
    ovr_d  = ovr_q | (wrap & pend_q & ~clr);

`ifdef SCHED_TIMEOUT_EN
    wd_d = ((state_q == REF_WAIT || state_q == RD_WAIT) && state_d == state_q) ? wd_q + 1'b1 : '0;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      pend_q    <= 1'b0;
      ovr_q     <= 1'b0;
      ref_row_q <= '0;
      addr_q    <= '0;
      wr_cnt_q  <= '0;
      we_q      <= 1'b0;
      dram_q    <= 1'b0;
      dec_q     <= 1'b0;
      sref_q    <= 1'b0;
      sdac_q    <= 1'b0;
      gd_q      <= 1'b0;
      gm_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= wrap ? '0 : timer_q + 1'b1;
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
      ref_row_q <= ref_row_d;
      addr_q    <= addr_d;
      wr_cnt_q  <= wr_cnt_d;
      we_q      <= we_d;
      dram_q    <= dram_d;
      dec_q     <= dec_d;
      sref_q    <= sref_d;
      sdac_q    <= sdac_d;
      gd_q      <= gd_d;
      gm_q      <= gm_d;
      busy_q    <= busy_d;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      wd_q  <= '0;
      tmo_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      tmo_q <= tmo_q | tmo_set;
    end
  end
  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign ADDR            = addr_q;
  assign WE              = we_q;
  assign DRAM_EN         = dram_q;
  assign DEC_EN          = dec_q;
  assign start_refresh   = sref_q;
  assign start_DAC       = sdac_q;
  assign gnt_dac         = gd_q;
  assign gnt_mav         = gm_q;
  assign busy            = busy_q;
  assign refresh_overrun = ovr_q;

endmodule

// File: tb/tb_cim_array_scheduler.sv
// tb/tb_cim_array_scheduler.sv - randomized bench for cim_array_scheduler against an operation-phase reference model
module tb_cim_array_scheduler;
  localparam int AW = 6, ROWS = 64, PER = 1024, WRC = 2, TMO = 255;

  logic CLK = 1'b0, RST = 1'b1;
  logic req_dac = 1'b0, req_mav = 1'b0, refresh_finish = 1'b0, ADC_finish = 1'b0;
  logic [AW-1:0] req_dac_addr = '0, req_mav_addr = '0;
  logic [AW-1:0] ADDR;
  logic WE, DRAM_EN, DEC_EN, start_refresh, start_DAC, gnt_dac, gnt_mav, busy;
  logic refresh_overrun, timeout_err;

  cim_array_scheduler #(.ADDR_W(AW), .ROWS(ROWS), .REFRESH_PERIOD(PER),
                        .WR_CYCLES(WRC), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .req_dac(req_dac), .req_dac_addr(req_dac_addr),
    .req_mav(req_mav), .req_mav_addr(req_mav_addr), .refresh_finish(refresh_finish),
    .ADC_finish(ADC_finish), .ADDR(ADDR), .WE(WE), .DRAM_EN(DRAM_EN), .DEC_EN(DEC_EN),
    .start_refresh(start_refresh), .start_DAC(start_DAC), .gnt_dac(gnt_dac),
    .gnt_mav(gnt_mav), .busy(busy), .refresh_overrun(refresh_overrun), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0, n_fail = 0, cyc = 0;
  // Model: current operation (0 none, 1 refresh, 2 read, 3 write) and its cycle index (1 = setup).
  int m_timer, m_row, m_op, m_t, m_addr;
  bit m_pend, m_ovr, m_tmo, m_gd, m_gm;
  int ref_delay = -1, adc_delay = -1, ref_due = -1, adc_due = -1;
  bit en_dac = 0, en_mav = 0, noise = 0, logging = 0;
  int first_ref = -1, sd_cyc = -1, n_gd = 0, nref = 0, ev = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_timer = 0; m_row = 0; m_op = 0; m_t = 0; m_addr = 0;
    m_pend = 0; m_ovr = 0; m_tmo = 0; m_gd = 0; m_gm = 0;
  endtask

  task automatic model_step();
    bit wrap, clr, done;
    if (RST) begin
      model_reset();
      return;
    end
    wrap = (m_timer == PER - 1);
    clr = 0; done = 0; m_gd = 0; m_gm = 0;
    if (m_op == 0) begin
      if (m_pend) begin m_op = 1; m_addr = m_row; end
      else if (req_dac) begin m_op = 2; m_addr = int'(req_dac_addr); end
      else if (req_mav) begin m_op = 3; m_addr = int'(req_mav_addr); end
      m_t = 1;
    end else begin
      if (m_op == 1 && m_t >= 3 && refresh_finish) begin
        done = 1; clr = 1; m_row = (m_row + 1) % ROWS;
      end
      if (m_op == 2 && m_t >= 3 && ADC_finish) begin done = 1; m_gd = 1; end
      if (m_op == 3 && m_t == WRC + 1) begin done = 1; m_gm = 1; end
`ifdef SCHED_TIMEOUT_EN
      if ((m_op == 1 || m_op == 2) && !done && m_t - 2 == TMO) begin done = 1; m_tmo = 1; end
`endif
      if (done) begin m_op = 0; m_t = 0; end
      else m_t++;
    end
    if (wrap) begin
      if (m_pend && !clr) m_ovr = 1;
      m_pend = 1;
    end else if (clr) m_pend = 0;
    m_timer = (m_timer + 1) % PER;
  endtask

  task automatic run(input int n);
    logic [7:0] exp_ctrl;
    bit we_e;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      model_step();
      cyc++;
      #1;
      we_e = (m_op == 3 && m_t >= 2);
      exp_ctrl = {we_e, (m_op == 1 || m_op == 2 || we_e), (m_op != 0),
                  (m_op == 1 && m_t == 2), (m_op == 2 && m_t == 2), m_gd, m_gm, (m_op != 0)};
      check_eq("ADDR", ADDR, (m_op != 0) ? m_addr : 0);
      check_eq("we_dram_dec_sref_sdac_gd_gm_busy",
               {WE, DRAM_EN, DEC_EN, start_refresh, start_DAC, gnt_dac, gnt_mav, busy}, exp_ctrl);
      check_eq("overrun_timeout", {refresh_overrun, timeout_err}, {m_ovr, m_tmo});
      if (start_refresh) begin
        nref++;
        if (first_ref < 0) first_ref = cyc;
        if (ref_delay >= 0) ref_due = cyc + ((ref_delay == 0) ? int'($urandom_range(1, 8)) : ref_delay);
      end
      if (start_DAC) begin
        sd_cyc = cyc;
        if (adc_delay >= 0) adc_due = cyc + ((adc_delay == 0) ? int'($urandom_range(1, 8)) : adc_delay);
      end
      if (gnt_dac) n_gd++;
      if (logging && start_refresh) ev = ev * 4 + 1;
      if (logging && start_DAC) ev = ev * 4 + 2;
      if (logging && gnt_mav) ev = ev * 4 + 3;
      refresh_finish = (cyc == ref_due) || (noise && $urandom_range(0, 7) == 0);
      ADC_finish = (cyc == adc_due) || (noise && $urandom_range(0, 7) == 0);
      if (gnt_dac) req_dac = 0;
      else if (req_dac && m_op == 2 && noise && $urandom_range(0, 15) == 0) req_dac = 0;
      else if (!req_dac && en_dac && $urandom_range(0, 3) == 0) begin
        req_dac = 1; req_dac_addr = AW'($urandom);
      end
      if (gnt_mav) req_mav = 0;
      else if (req_mav && m_op == 3 && noise && $urandom_range(0, 15) == 0) req_mav = 0;
      else if (!req_mav && en_mav && $urandom_range(0, 3) == 0) begin
        req_mav = 1; req_mav_addr = AW'($urandom);
      end
    end
  endtask

  initial begin
    int guard, c0, g0;
    model_reset();
    RST = 1; run(2); RST = 0;
    cyc = 0;

    // First refresh after an idle period.
    ref_delay = 3; first_ref = -1;
    run(1040);
    check_eq("first_start_refresh_cycle", first_ref, 1026);

    // Single read, ADC done five cycles after start_DAC.
    adc_delay = 5; sd_cyc = -1; g0 = n_gd;
    c0 = cyc; req_dac = 1; req_dac_addr = 6'h15;
    run(14);
    check_eq("start_dac_latency", sd_cyc - c0, 2);
    check_eq("single_gnt_dac", n_gd - g0, 1);

    // Refresh pending plus both requests: refresh, then read, then write.
    ref_delay = 2; adc_delay = 3; guard = 0;
    while ((m_timer != 0 || m_op != 0) && guard < 2100) begin run(1); guard++; end
    check_eq("sync_to_wrap", guard < 2100, 1);
    req_dac = 1; req_dac_addr = 6'h2A; req_mav = 1; req_mav_addr = 6'h11;
    ev = 0; logging = 1;
    run(40);
    logging = 0;
    check_eq("order_ref_dac_mav", ev, 27);

    // Random traffic long enough for the refresh row to wrap.
    en_dac = 1; en_mav = 1; noise = 1; ref_delay = 0; adc_delay = 0; nref = 0;
    run(65 * PER + 100);
    check_eq("refresh_count_wrap", nref >= 65, 1);

    // Withheld refresh_finish leads to overrun, which stays sticky.
    en_dac = 0; en_mav = 0; noise = 0; ref_delay = -1; adc_delay = 3;
    run(2 * PER + 20);
    check_eq("overrun_set", refresh_overrun, 1);
    ref_delay = 3; ref_due = cyc + 1;
    run(PER + 50);
    check_eq("overrun_sticky", refresh_overrun, 1);

    // Reset in the middle of RD_WAIT, then the held request is served normally.
    adc_delay = -1; adc_due = -1; req_dac = 1; req_dac_addr = 6'h0C; guard = 0;
    while (!(m_op == 2 && m_t >= 3) && guard < 40) begin run(1); guard++; end
    check_eq("reach_rd_wait", guard < 40, 1);
    RST = 1; run(1); RST = 0;
    check_eq("reset_outputs_idle", {busy, gnt_dac, DEC_EN, ADDR}, 0);
    ref_due = -1; adc_due = -1; adc_delay = 2; g0 = n_gd;
    run(20);
    check_eq("gnt_after_reset", n_gd - g0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
